// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC owner and two-slot fetch pipeline applying predictor redirects/squashes
// Optional FETCH_PERF_CNT_EN adds saturating redirect/squash counters.
module fetch_redirect_unit #(
  parameter int                PC_W   = 12,
  parameter int                INST_W = 16,
  parameter logic [INST_W-1:0] NOP    = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic [INST_W-1:0] inst,
  output logic              pred_enable,
  input  logic [PC_W-1:0]   resultpc,
  input  logic [1:0]        flash,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_redirects,
  output logic [15:0]       perf_squashed
`endif
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic                s0_v, s1_v;
  logic [INST_W-1:0]   s0_inst, s1_inst;
  logic [PC_W-1:0]     s0_pc, s1_pc;
  logic                advance;
  logic                sq1, sq2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // BOOT holds for one cycle so the predictor's flag pipeline can settle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign advance = (state_q == RUN) && (!s1_v || out_ready);
  assign sq1     = advance && (flash == 2'b01);
  assign sq2     = advance && (flash == 2'b10);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      s0_v    <= 1'b0;
      s0_inst <= NOP;
      s0_pc   <= '0;
      s1_v    <= 1'b0;
      s1_inst <= NOP;
      s1_pc   <= '0;
    end else if (advance) begin
      pc_q    <= resultpc;
      s1_v    <= s0_v & ~sq2;
      s1_inst <= sq2 ? NOP : s0_inst;
      s1_pc   <= s0_pc;
      s0_v    <= ~(sq1 | sq2);
      s0_inst <= (sq1 | sq2) ? NOP : imem_rdata;
      s0_pc   <= pc_q;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = imem_rdata;
  assign pred_enable = advance;
  assign out_valid   = s1_v;
  assign out_pc      = s1_pc;
  assign out_inst    = s1_v ? s1_inst : NOP;

`ifdef FETCH_PERF_CNT_EN
  logic [1:0]  squash_n;
  logic [16:0] red_sum, sq_sum;

  // The incoming S0 word is always live when advancing; a double squash also drops the old S0.
  always_comb begin
    squash_n = 2'd0;
    if (sq1)      squash_n = 2'd1;
    else if (sq2) squash_n = 2'd1 + {1'b0, s0_v};
  end

  assign red_sum = {1'b0, perf_redirects} + 17'd1;
  assign sq_sum  = {1'b0, perf_squashed} + {15'b0, squash_n};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_redirects <= 16'h0000;
      perf_squashed  <= 16'h0000;
    end else if (sq1 || sq2) begin
      perf_redirects <= red_sum[16] ? 16'hFFFF : red_sum[15:0];
      perf_squashed  <= sq_sum[16]  ? 16'hFFFF : sq_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - table-driven directed bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [11:0] pc;
  logic [15:0] inst;
  logic        pred_enable;
  logic [11:0] resultpc;
  logic [1:0]  flash;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [11:0] out_pc;
  logic        rd;
  logic [11:0] rpc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_redirects;
  logic [15:0] perf_squashed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // ROM[k] = 16'h1000 + k; default next PC is sequential.
  assign imem_rdata = 16'h1000 + {4'h0, imem_addr};
  assign resultpc   = rd ? rpc : pc + 12'd1;

  fetch_redirect_unit dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .inst        (inst),
    .pred_enable (pred_enable),
    .resultpc    (resultpc),
    .flash       (flash),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_squashed  (perf_squashed)
`endif
  );

  typedef struct {
    logic [1:0]  fl;
    logic        rd;
    logic [11:0] rpc;
    logic        rdy;
    logic        en;
    logic        v;
    logic [11:0] opc;
    logic [11:0] addr;
  } vec_t;

  vec_t vt[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // fl, rd, rpc, rdy | pre-edge en | post-edge out_valid, out_pc, imem_addr
    vt[0]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000};
    vt[1]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 12'h001};
    vt[2]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000, 12'h002};
    vt[3]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h001, 12'h003};
    vt[4]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h002, 12'h004};
    vt[5]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h003, 12'h005};
    vt[6]  = '{2'b01, 1'b1, 12'h020, 1'b1, 1'b1, 1'b1, 12'h004, 12'h020};
    vt[7]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h005, 12'h021};
    vt[8]  = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h020, 12'h022};
    vt[9]  = '{2'b00, 1'b1, 12'h006, 1'b1, 1'b1, 1'b1, 12'h021, 12'h006};
    vt[10] = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h022, 12'h007};
    vt[11] = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h006, 12'h008};
    vt[12] = '{2'b10, 1'b1, 12'h040, 1'b1, 1'b1, 1'b0, 12'h007, 12'h040};
    vt[13] = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h008, 12'h041};
    vt[14] = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h040, 12'h042};
    vt[15] = '{2'b00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h040, 12'h042};
    vt[16] = '{2'b10, 1'b1, 12'h123, 1'b0, 1'b0, 1'b1, 12'h040, 12'h042};
    vt[17] = '{2'b01, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h040, 12'h042};
    vt[18] = '{2'b00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h040, 12'h042};
    vt[19] = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h041, 12'h043};
    vt[20] = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h042, 12'h044};
    vt[21] = '{2'b11, 1'b1, 12'hFFE, 1'b1, 1'b1, 1'b1, 12'h043, 12'hFFE};
    vt[22] = '{2'b11, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h044, 12'hFFF};
    vt[23] = '{2'b11, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hFFE, 12'h000};
    vt[24] = '{2'b11, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hFFF, 12'h001};
    vt[25] = '{2'b00, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'h000, 12'h002};

    reset     = 1'b1;
    flash     = 2'b00;
    rd        = 1'b0;
    rpc       = 12'h000;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_inst", {16'b0, out_inst}, 32'h0);
    check("reset out_pc", {20'b0, out_pc}, 32'h0);
    check("reset imem_addr", {20'b0, imem_addr}, 32'h0);
    check("reset pred_enable", {31'b0, pred_enable}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      flash     = vt[i].fl;
      rd        = vt[i].rd;
      rpc       = vt[i].rpc;
      out_ready = vt[i].rdy;
      #1;
      check($sformatf("v%0d pred_enable", i), {31'b0, pred_enable}, {31'b0, vt[i].en});
      @(posedge clock);
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].v});
      check($sformatf("v%0d out_pc", i), {20'b0, out_pc}, {20'b0, vt[i].opc});
      check($sformatf("v%0d out_inst", i), {16'b0, out_inst},
            vt[i].v ? {16'b0, 16'h1000 + {4'h0, vt[i].opc}} : 32'h0);
      check($sformatf("v%0d imem_addr", i), {20'b0, imem_addr}, {20'b0, vt[i].addr});
      check($sformatf("v%0d pc", i), {20'b0, pc}, {20'b0, vt[i].addr});
      check($sformatf("v%0d inst", i), {16'b0, inst}, {16'b0, 16'h1000 + {4'h0, vt[i].addr}});
      @(negedge clock);
    end

`ifdef FETCH_PERF_CNT_EN
    check("perf_redirects", {16'b0, perf_redirects}, 32'd2);
    check("perf_squashed", {16'b0, perf_squashed}, 32'd3);
`endif

    // Mid-stream reset: both slots live, outputs must clear without a clock edge.
    flash = 2'b00;
    rd    = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst out_inst", {16'b0, out_inst}, 32'h0);
    check("midrst out_pc", {20'b0, out_pc}, 32'h0);
    check("midrst imem_addr", {20'b0, imem_addr}, 32'h0);
    check("midrst pred_enable", {31'b0, pred_enable}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("reboot pred_enable", {31'b0, pred_enable}, 32'd0);
    begin
      int edges = 0;
      while (!out_valid && edges < 10) begin
        @(posedge clock);
        #1;
        edges++;
      end
      check("reboot edges to valid", edges, 32'd3);
      check("reboot out_pc", {20'b0, out_pc}, 32'h0);
      check("reboot out_inst", {16'b0, out_inst}, 32'h1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Fetch-side partner of the branch-prediction unit. It owns the program counter, fetches 16-bit instructions from instruction memory, and supplies the predictor with `pc`, `inst` and `enable`. It applies the predictor's `resultpc` next-PC and `flash` squash requests to a two-slot fetch pipeline, then hands surviving instructions to decode over a valid/ready handshake.

## Interface
- `PC_W`, 12: PC / instruction-address width.
- `INST_W`, 16: instruction width.
- `NOP`, 16'h0000: encoding driven for squashed or empty slots.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `imem_addr` out PC_W: instruction-memory address, equal to `pc_q`.
- `imem_rdata` in INST_W: combinational instruction-memory read data for `imem_addr`.
- `pc` out PC_W: current fetch PC, sent to the predictor.
- `inst` out INST_W: current fetch word, sent to the predictor.
- `pred_enable` out 1: advance strobe, sent to the predictor `enable`.
- `resultpc` in PC_W: next fetch PC from the predictor.
- `flash` in 2: squash request. 00 = none, 01 = squash 1 youngest, 10 = squash 2 youngest, 11 = treated as 00.
- `out_valid` out 1: decode slot holds a live instruction.
- `out_ready` in 1: decode accepts this cycle.
- `out_inst` out INST_W: instruction to decode.
- `out_pc` out PC_W: PC of `out_inst`.

## Operation
- State:
  - `pc_q`.
  - Slot S0 (youngest) and slot S1 (oldest). Each slot holds `{v, inst, pc}`.
  - A 2-state FSM: BOOT and RUN.
- `advance = (state==RUN) && (!S1.v || out_ready)`. `pred_enable = advance`.
- BOOT:
  - Entered on reset.
  - Lasts exactly 1 cycle, with `advance=0`, so the predictor's flag pipeline settles.
  - Then unconditionally moves to RUN. RUN has no exit except reset.
- When `advance` is 1, at the clock edge:
  - `pc_q <= resultpc`.
  - S1 <= S0.
  - S0 <= `{1, imem_rdata, pc_q}`.
- Squash, applied in the same edge:
  - `flash`=01: the new S0 entry is written with v=0 and inst=NOP.
  - `flash`=10: the new S0 entry and the new S1 entry are both written with v=0 and inst=NOP.
- When `advance` is 0:
  - All state holds.
  - `flash` is ignored, because the predictor is frozen.
- Outputs from S1:
  - `out_valid=S1.v`.
  - `out_pc=S1.pc`.
  - `out_inst = S1.v ? S1.inst : NOP`.
- PC arithmetic is modulo 2^PC_W. Wrap-around from 12'hFFF to 12'h000 is legal and produces no special behaviour.
- `inst`/`pc` toward the predictor are `imem_rdata`/`pc_q` in every state.

## Timing
- Reset values:
  - `pc_q`=0.
  - S0 and S1 both v=0, inst=NOP, pc=0.
  - FSM state is BOOT.
  - Resulting outputs: `pred_enable`=0, `out_valid`=0, `out_inst`=NOP, `out_pc`=0, `imem_addr`=0.
- Latency: a word fetched at edge N (captured into S0) appears on `out_*` after edge N+1, i.e. 2 advancing edges after its PC was on `imem_addr`.
- First `out_valid`=1 occurs after the 3rd edge following reset release: 1 BOOT edge, then 2 fills.
- Handshake:
  - A transfer occurs when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, all `out_*` are stable, `pred_enable`=0, and `imem_addr` is stable.
  - `out_ready` may be asserted while `out_valid`=0. Bubbles are drained with no handshake.
- Squash during stall: impossible by construction. The bench must still check that `flash`≠00 with `advance`=0 changes nothing.
- Reset asserted mid-stream:
  - All slots are invalidated immediately (asynchronously).
  - No partial transfer is reported on that cycle.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds these outputs.
  - `perf_redirects` out 16: counts advancing cycles with `flash`∈{01,10}. Saturates at 16'hFFFF.
  - `perf_squashed` out 16: adds the number of valid slots actually discarded (0–2). Saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: these ports and counters do not exist. Functional behaviour is identical in both builds.

## Test plan
- Reset, then ramp: release reset with ROM[k]=16'h1000+k, `resultpc`=`pc`+1, `out_ready`=1 → `out_valid` first rises after the 3rd edge with `out_pc`=0, `out_inst`=16'h1000. Thereafter one instruction per cycle, consecutive PCs.
- Single squash: while fetching pc=5, drive `flash`=01, `resultpc`=12'h020 → instruction at pc 5 never appears on `out_*` (a NOP bubble with `out_valid`=0 instead); the next valid after it is pc 12'h020. With the macro, `perf_redirects`=1 and `perf_squashed`=1.
- Double squash: while fetching pc=8, drive `flash`=10, `resultpc`=12'h040 → pcs 7 and 8 never appear on `out_*`; pc 12'h040 follows pc 6. `perf_squashed`=2.
- Backpressure: hold `out_ready`=0 for 4 cycles while `out_valid`=1 → `out_*` and `imem_addr` are frozen and `pred_enable`=0. On release, no instruction is lost or duplicated.
- Wrap and reserved code: `resultpc` sequence 12'hFFE, 12'hFFF, 12'h000 with `flash`=11 → all three words are delivered in order and nothing is squashed.
- Mid-stream reset: assert `reset` while S0 and S1 are valid → `out_valid` drops in the same cycle. After release, the ramp restarts at pc 0 with the BOOT cycle.
